// File: rtl/des_pkg.sv
// Shared DES definitions used by the iterative decrypt core and its f-function.
//
// Contents:
//   NUM_ROUNDS / LAST_CNT  : round count and final value of the round counter
//   state_t                : controller states IDLE -> ROUND -> DONE
//   RSHIFT / LSHIFT        : per-round C/D rotation amounts (decrypt / encrypt)
//   IP, FP, E, P, PC1, PC2 : DES permutation tables, DES bit 1 is the MSB
//   SBOX                   : S1..S8, each indexed by {row[1:0], col[3:0]}
//   ip_perm .. pc2_perm    : table-driven permutation helpers
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int RSHIFT [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int LSHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  localparam int E_T [48] = '{
    32,1,2,3,4,5,     4,5,6,7,8,9,       8,9,10,11,12,13,   12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};

  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14,6,61,53,45,37,29,  21,13,5,28,20,12,4};

  localparam int PC2_T [48] = '{
    14,17,11,24,1,5,   3,28,15,6,21,10,   23,19,12,4,26,8,   16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Each helper walks its table from DES bit 1 (MSB) downwards and shifts
  // the selected source bit into the result, so output bit 1 ends up on top.
  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      idx = 64 - IP_T[i];
      r = {r[62:0], d[idx[5:0]]};
    end
    return r;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    logic [63:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      idx = 64 - FP_T[i];
      r = {r[62:0], d[idx[5:0]]};
    end
    return r;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] d);
    logic [47:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 32 - E_T[i];
      r = {r[46:0], d[idx[4:0]]};
    end
    return r;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] d);
    logic [31:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      idx = 32 - P_T[i];
      r = {r[30:0], d[idx[4:0]]};
    end
    return r;
  endfunction

  // Parity bits 8,16,..,64 never appear in PC1, so they are dropped here.
  function automatic logic [55:0] pc1_perm(input logic [63:0] d);
    logic [55:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      idx = 64 - PC1_T[i];
      r = {r[54:0], d[idx[5:0]]};
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] d);
    logic [47:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 56 - PC2_T[i];
      r = {r[46:0], d[idx[5:0]]};
    end
    return r;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[0], x[27:1]};
      2:       return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[26:0], x[27]};
      2:       return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_decrypt_iter_if.sv
// Request/result bundle of the iterative DES core.
//   start       : request, honoured only while busy is low
//   cipher_text : 64-bit input block, DES bit 1 = [63]
//   key         : 64-bit key including parity bits
//   plain_text  : 64-bit result, held until the next completion
//   dat_valid   : one-cycle pulse marking a fresh plain_text
//   busy        : high from the cycle after accept through the dat_valid cycle
//   enc         : direction select, present only with DES_ENC_MODE_EN defined
// master = requester side, slave = core side.
interface des_decrypt_iter_if;
  logic        start;
  logic [63:0] cipher_text;
  logic [63:0] key;
  logic [63:0] plain_text;
  logic        dat_valid;
  logic        busy;
`ifdef DES_ENC_MODE_EN
  logic        enc;

  modport master (output start, cipher_text, key, enc,
                  input  plain_text, dat_valid, busy);
  modport slave  (input  start, cipher_text, key, enc,
                  output plain_text, dat_valid, busy);
`else
  modport master (output start, cipher_text, key,
                  input  plain_text, dat_valid, busy);
  modport slave  (input  start, cipher_text, key,
                  output plain_text, dat_valid, busy);
`endif
endinterface

// File: rtl/des_round_f.sv
// Combinational DES f-function: f(R, K) = P(S(E(R) xor K)).
//   r_in  : 32-bit right half
//   k_in  : 48-bit round subkey
//   f_out : 32-bit f result
// Shared by the encrypt and decrypt iterative cores.
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r_in,
  input  logic [47:0] k_in,
  output logic [31:0] f_out
);

  logic [47:0] x;
  logic [31:0] s_out;

  assign x = e_expand(r_in) ^ k_in;

  // Each 6-bit chunk picks its row from the outer bits and its column from
  // the inner four, which is exactly the {row, col} index of SBOX.
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] six;
    assign six = x[47-6*j -: 6];
    assign s_out[31-4*j -: 4] = 4'(SBOX[j][{six[5], six[0], six[4:1]}]);
  end

  assign f_out = p_perm(s_out);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core, one Feistel round per clock.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : des_decrypt_iter_if.slave (start/cipher_text/key in,
//         plain_text/dat_valid/busy out)
// Subkeys K16..K1 are produced on the fly by rotating C/D right.
// Optional build macro DES_ENC_MODE_EN adds bus.enc; with enc=1 C/D rotate
// left instead and the core encrypts. Timing is identical in both builds.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic clk,
  input  logic rst,
  des_decrypt_iter_if.slave bus
);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [31:0] l_reg, r_reg, f_out, r_next;
  logic [27:0] c_reg, d_reg, c_rot, d_rot;
  logic [47:0] subkey;
  logic [63:0] ip_out, plain_q;
  logic [55:0] pc1_out;
  logic        valid_q, accept, last_round;
`ifdef DES_ENC_MODE_EN
  logic        enc_q;
`endif

  assign accept     = (state == IDLE) && bus.start;
  assign last_round = (state == ROUND) && (cnt == LAST_CNT);
  assign ip_out     = ip_perm(bus.cipher_text);
  assign pc1_out    = pc1_perm(bus.key);
  assign subkey     = pc2_perm({c_rot, d_rot});
  assign r_next     = l_reg ^ f_out;

  des_round_f u_round_f (
    .r_in  (r_reg),
    .k_in  (subkey),
    .f_out (f_out)
  );

  // Rotate C/D ahead of the round so the subkey for round cnt is available
  // in the same cycle; the rotated halves are also what gets stored.
  always_comb begin
    c_rot = rotr28(c_reg, RSHIFT[cnt]);
    d_rot = rotr28(d_reg, RSHIFT[cnt]);
`ifdef DES_ENC_MODE_EN
    if (enc_q) begin
      c_rot = rotl28(c_reg, LSHIFT[cnt]);
      d_rot = rotl28(d_reg, LSHIFT[cnt]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = ROUND;
      ROUND:   if (cnt == LAST_CNT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The result is loaded on the last round edge from the swapped, just
  // computed halves, so it is already valid during the DONE cycle that
  // carries the dat_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      l_reg   <= '0;
      r_reg   <= '0;
      c_reg   <= '0;
      d_reg   <= '0;
      plain_q <= '0;
      valid_q <= 1'b0;
`ifdef DES_ENC_MODE_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      valid_q <= last_round;
      if (accept) begin
        l_reg <= ip_out[63:32];
        r_reg <= ip_out[31:0];
        c_reg <= pc1_out[55:28];
        d_reg <= pc1_out[27:0];
        cnt   <= '0;
`ifdef DES_ENC_MODE_EN
        enc_q <= bus.enc;
`endif
      end else if (state == ROUND) begin
        l_reg <= r_reg;
        r_reg <= r_next;
        c_reg <= c_rot;
        d_reg <= d_rot;
        if (last_round) plain_q <= fp_perm({r_next, r_reg});
        else            cnt     <= cnt + 4'd1;
      end
    end
  end

  assign bus.plain_text = plain_q;
  assign bus.dat_valid  = valid_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter.
// Known-answer vectors plus random blocks are compared with a textbook DES
// model (forward key schedule, keys applied in reverse for decryption).
// With DES_ENC_MODE_EN defined, encrypt and round-trip blocks are added.
module tb_des_decrypt_iter;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] got, got2, p, k, c;

  des_decrypt_iter_if bus();

  des_decrypt_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edge active.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tables, written independently from the textbook definitions.
  int ip_t[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                   64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t[$]  = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                   37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                   34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                   16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int ls_t[$]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int s_t[$]   = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Generic permutation: output bit n (1 = MSB) is input bit t[n-1] of a
  // win-bit word; the result is right-aligned.
  function automatic logic [63:0] perm(input logic [63:0] x, input int win, input int t[$]);
    logic [63:0] r;
    r = '0;
    foreach (t[i]) r = (r << 1) | ((x >> (win - t[i])) & 64'd1);
    return r;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] kk);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  six;
    int          row, col;
    x = 48'(perm(64'(r), 32, e_t)) ^ kk;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = 6'(x >> (42 - 6 * j));
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s   = (s << 4) | 32'(s_t[64 * j + 16 * row + col]);
    end
    return 32'(perm(64'(s), 32, p_t));
  endfunction

  // Textbook DES: build K1..K16 by left shifts, then run 16 rounds using
  // them forward (encrypt) or backward (decrypt).
  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] kk,
                                          input logic dec);
    logic [27:0] cc, dd;
    logic [55:0] cd;
    logic [47:0] ks [16];
    logic [63:0] x;
    logic [31:0] l, r, t;
    cd = 56'(perm(kk, 64, pc1_t));
    cc = cd[55:28];
    dd = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      cc    = (cc << ls_t[i]) | (cc >> (28 - ls_t[i]));
      dd    = (dd << ls_t[i]) | (dd >> (28 - ls_t[i]));
      ks[i] = 48'(perm(64'({cc, dd}), 56, pc2_t));
    end
    x = perm(blk, 64, ip_t);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_ref(r, dec ? ks[15 - i] : ks[i]);
      l = t;
    end
    return perm({r, l}, 64, fp_t);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One clock step; everything is driven and sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one block and follow it to completion. Inputs are scrambled after
  // the start cycle; with poke set, extra starts are pulsed at T+5 and T+17.
  task automatic applyStimulus(input logic [63:0] ct, input logic [63:0] kk, input logic e,
                               input logic [63:0] exp, input string tag, input bit poke,
                               output logic [63:0] res);
    int          n;
    bit          busy_ok, seen;
    logic [63:0] ref_val;
    ref_val = des_ref(ct, kk, !e);
    bus.start       = 1'b1;
    bus.cipher_text = ct;
    bus.key         = kk;
`ifdef DES_ENC_MODE_EN
    bus.enc         = e;
`endif
    n = 0; busy_ok = 1'b1; seen = 1'b0; res = '0;
    while (!seen && n < 40) begin
      step();
      n++;
      bus.start       = 1'b0;
      bus.cipher_text = rand64();
      bus.key         = rand64();
`ifdef DES_ENC_MODE_EN
      bus.enc         = ~e;
`endif
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.dat_valid === 1'b1) begin
        seen = 1'b1;
        res  = bus.plain_text;
      end
      if (poke && (n == 5 || n == 17)) bus.start = 1'b1;
    end
    checkOutput({tag, " latency"}, 64'(n), 64'd17);
    checkOutput({tag, " busy"}, 64'(busy_ok), 64'd1);
    checkOutput({tag, " plain"}, res, exp);
    checkOutput({tag, " model"}, res, ref_val);
    step();
    bus.start = 1'b0;
    checkOutput({tag, " pulse"}, 64'(bus.dat_valid), 64'd0);
    checkOutput({tag, " idle"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, " hold"}, bus.plain_text, exp);
  endtask

  // Start a block, hit it with a one-cycle reset at T+8, expect a clean abort.
  task automatic abortRun(input logic [63:0] ct, input logic [63:0] kk);
    bit seen;
    bus.start       = 1'b1;
    bus.cipher_text = ct;
    bus.key         = kk;
    for (int n = 1; n <= 8; n++) begin
      step();
      bus.start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort busy", 64'(bus.busy), 64'd0);
    checkOutput("abort valid", 64'(bus.dat_valid), 64'd0);
    checkOutput("abort plain", bus.plain_text, 64'd0);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (bus.dat_valid !== 1'b0) seen = 1'b1;
    end
    checkOutput("abort no pulse", 64'(seen), 64'd0);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst             = 1'b1;
    bus.start       = 1'b1;
    bus.cipher_text = CT1;
    bus.key         = KEY1;
`ifdef DES_ENC_MODE_EN
    bus.enc         = 1'b0;
`endif
    repeat (3) step();
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset valid", 64'(bus.dat_valid), 64'd0);
    checkOutput("reset plain", bus.plain_text, 64'd0);

    applyStimulus(CT1, KEY1, 1'b0, PT1, "kat1", 1'b0, got);
    applyStimulus(64'h0, 64'h0E329232EA6D0D73, 1'b0, 64'h8787878787878787, "kat2", 1'b0, got);
    applyStimulus(CT1, KEY1, 1'b0, PT1, "ignore", 1'b1, got);
    p = rand64();
    k = rand64();
    applyStimulus(des_ref(p, k, 1'b0), k, 1'b0, p, "back2back", 1'b0, got);
    abortRun(CT1, KEY1);
    applyStimulus(CT1, KEY1, 1'b0, PT1, "after rst", 1'b0, got);
    applyStimulus(CT1, KEY1 ^ 64'h0101010101010101, 1'b0, PT1, "parity", 1'b0, got);

    for (int i = 0; i < 30; i++) begin
      p = rand64();
      k = rand64();
      applyStimulus(des_ref(p, k, 1'b0), k, 1'b0, p, "random dec", 1'b0, got);
    end

`ifdef DES_ENC_MODE_EN
    applyStimulus(PT1, KEY1, 1'b1, CT1, "enc kat", 1'b0, got);
    applyStimulus(got, KEY1, 1'b0, PT1, "enc back", 1'b0, got2);
    for (int i = 0; i < 1000; i++) begin
      p = rand64();
      k = rand64();
      c = des_ref(p, k, 1'b0);
      applyStimulus(p, k, 1'b1, c, "trip enc", 1'b0, got);
      applyStimulus(got, k, 1'b0, p, "trip dec", 1'b0, got2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
